// File: rtl/result_display_pkg.sv
// result_display_pkg: shared types and seven-segment glyph constants for the result display
package result_display_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  typedef struct packed {
    logic       blank;
    logic [3:0] nib;
  } digit_t;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam digit_t BLANK_DIGIT = '{blank: 1'b1, nib: 4'h0};
endpackage

// File: rtl/result_display_if.sv
// result_display_if: result/op-select load port (res_i, sel_i, load_i, dec_i) and display drive (busy_o, an_o, seg_o, dp_o)
interface result_display_if;
  logic [7:0] res_i;
  logic [1:0] sel_i;
  logic       load_i;
  logic       dec_i;
  logic       busy_o;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  modport master (output res_i, sel_i, load_i, dec_i, input busy_o, an_o, seg_o, dp_o);
  modport slave (input res_i, sel_i, load_i, dec_i, output busy_o, an_o, seg_o, dp_o);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: digit code (blank flag + nibble) in d, active-low gfedcba pattern out on seg
module seg7_decoder
  import result_display_pkg::*;
(
  input  digit_t     d,
  output logic [6:0] seg
);
  assign seg = d.blank ? BLANK : GLYPHS[d.nib];
endmodule

// File: rtl/result_display.sv
// result_display: hex/decimal 4-digit multiplexed seven-segment output stage; ports clk_i, rst_i (sync, high), bus (slave: res/sel/load/dec in, busy/an/seg/dp out)
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic             clk_i,
  input logic             rst_i,
  result_display_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  state_t        state, state_n;
  logic [19:0]   sh, adj, sh_n;
  logic [11:0]   bcd;
  logic [2:0]    cnt;
  logic [1:0]    sel_p, sel_d;
  digit_t        d0, d1, d2, cur;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? ((bus.load_i && bus.dec_i) ? CONV : IDLE)
                            : (cnt == 3'd7 ? IDLE : CONV);
  // one double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    adj = sh;
    for (int k = 0; k < 3; k++)
      if (adj[8+4*k +: 4] >= 4'd5) adj[8+4*k +: 4] = adj[8+4*k +: 4] + 4'd3;
    sh_n = {adj[18:0], 1'b0};
    bcd  = sh_n[19:8];
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      d0    <= '0;
      d1    <= '0;
      d2    <= BLANK_DIGIT;
      sel_d <= '0;
      sel_p <= '0;
      sh    <= '0;
      cnt   <= '0;
    end else if (state == IDLE && bus.load_i) begin
      sel_p <= bus.sel_i;
      cnt   <= '0;
      if (bus.dec_i) begin
        sh <= {12'b0, bus.res_i};
      end else begin
        d0    <= {1'b0, bus.res_i[3:0]};
        d1    <= {1'b0, bus.res_i[7:4]};
        d2    <= BLANK_DIGIT;
        sel_d <= bus.sel_i;
      end
    end else if (state == CONV) begin
      sh  <= sh_n;
      cnt <= cnt + 3'd1;
      // display only changes once the final BCD value exists
      if (cnt == 3'd7) begin
        d0    <= {1'b0, bcd[3:0]};
        d1    <= {bcd[11:4] == 8'd0, bcd[7:4]};
        d2    <= {bcd[11:8] == 4'd0, bcd[11:8]};
        sel_d <= sel_p;
      end
    end
  assign cur = idx == 2'd3 ? digit_t'({3'b000, sel_d}) : idx == 2'd2 ? d2 : idx[0] ? d1 : d0;
  seg7_decoder u_dec (.d(cur), .seg(bus.seg_o));
  assign bus.an_o   = ~(4'b0001 << idx);
  assign bus.dp_o   = ~&idx;
  assign bus.busy_o = state == CONV;
endmodule

// File: doc/result_display.md
# result_display

Output stage of the 4-bit ALU datapath. It consumes the 8-bit result and 2-bit op-select produced by the result multiplexer and drives a 4-digit, common-anode, time-multiplexed seven-segment display. The result can be shown as two hex digits, or as unsigned decimal 0–255 using a multi-cycle binary-to-BCD converter. Digit 3 always shows the op-select code.

## Interface
Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit stays lit. Legal range is ≥ 2; use 4 in simulation.

Ports:
- clk_i  input  1  single system clock; all state is on the rising edge
- rst_i  input  1  synchronous, active-high reset
- res_i  input  8  result byte from the multiplexer
- sel_i  input  2  op-select code accompanying res_i
- load_i  input  1  1-cycle strobe that captures res_i, sel_i and dec_i
- dec_i  input  1  display mode: 0 = hex, 1 = unsigned decimal
- busy_o  output  1  high while a decimal conversion is in progress
- an_o  output  4  digit enables, active-low, one-hot-low
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  output  1  decimal point, active-low

## Operation
- State machine has two states, IDLE and CONV.
- In IDLE, when load_i = 1:
  - Capture res_i, sel_i and dec_i.
  - If dec_i = 0, write the display registers directly; the state stays IDLE.
  - If dec_i = 1, load the shift-add-3 (double-dabble) converter and go to CONV.
- In CONV, run 8 iterations, one per cycle. Each iteration adds 3 to every BCD nibble that is ≥ 5, then shifts left by one.
  - After the 8th iteration, write the display registers and return to IDLE.
  - load_i is ignored in CONV; there is no queueing.
  - The display keeps the previous value until conversion completes; no partial values are ever shown.
- Digit mapping in hex mode:
  - d0 = res[3:0]
  - d1 = res[7:4]
  - d2 = blank
  - d3 = sel
- Digit mapping in decimal mode:
  - d0 = ones, d1 = tens, d2 = hundreds, d3 = sel
  - Leading-zero blanking: d2 is blank if hundreds = 0; d1 is blank if hundreds = 0 and tens = 0. d0 is never blanked.
- Scanning:
  - The prescaler counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - Scanning runs continuously and is unaffected by load_i or CONV.
- an_o = ~(1 << index).
- seg_o is the decoded glyph for the current digit; a blank digit gives 7'b1111111.
- dp_o = 0 only when index = 3, acting as a separator; otherwise dp_o = 1.
- Glyphs, active-low gfedcba:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110

## Timing
- Reset values:
  - state = IDLE, prescaler = 0, index = 0
  - display registers = hex mode, value 0x00, sel 0
  - busy_o = 0, an_o = 4'b1110, seg_o = 7'b1000000, dp_o = 1
- Reset has priority over everything. A reset during CONV aborts the conversion and clears the display registers to the reset values.
- an_o, seg_o and dp_o are combinational decodes of registered state (index and display registers); there is no extra output register.
- Hex load at edge t: the new value is visible from cycle t+1.
- Decimal load at edge t:
  - busy_o = 1 in cycles t+1..t+8.
  - The display registers update at the edge ending cycle t+8.
  - The new value is visible, and busy_o = 0, from cycle t+9.
- A load_i in the same cycle that CONV completes is ignored. A new load is accepted from cycle t+9.
- With REFRESH_DIV = N, each digit is lit for exactly N cycles and the full scan takes 4N cycles.

## Structure
- Shared package holds:
  - the state enum (IDLE, CONV)
  - the 16 glyph constants and the BLANK constant
  - the 5-bit digit code type: a blank flag plus a nibble
- Sub-module seg7_decoder: combinational, maps the 5-bit digit code to a 7-bit active-low pattern. It is instantiated once, after the digit-select mux.
- All remaining logic lives in result_display itself: the prescaler, the scan index, the IDLE/CONV FSM and the double-dabble datapath.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset and scan:
  - Stimulus: hold rst_i for 2 cycles, then release.
  - Response: an_o = 1110, seg_o = 1000000, busy_o = 0, dp_o = 1.
  - an_o steps 1101, 1011, 0111 every 4 cycles. dp_o = 0 only on 0111.
- Hex load:
  - Stimulus: load res_i = 0xA7, sel_i = 2, dec_i = 0.
  - Response: d0 = 1111000, d1 = 0001000, d2 = 1111111, d3 = 0100100. The value is visible the cycle after the load.
- Decimal 255:
  - Stimulus: load res_i = 0xFF, dec_i = 1.
  - Response: busy_o is high for exactly 8 cycles. Afterwards d0 = 0010010, d1 = 0010010, d2 = 0100100.
  - During busy, the old value is still shown.
- Decimal blanking:
  - Stimulus: load res_i = 0x07 in decimal mode.
  - Response: d1 and d2 are blank.
  - Stimulus: load res_i = 0x64 (100) in decimal mode.
  - Response: d0 = 1000000, d1 = 1000000, d2 = 1111001.
- Ignored load and abort:
  - Stimulus: load 0xFF in decimal mode, then pulse load_i with 0x11 during CONV.
  - Response: the final display is 255.
  - Stimulus: repeat the load, then assert rst_i in the 4th CONV cycle.
  - Response: busy_o = 0 and the display shows hex 00.
- Load independence of scan:
  - Stimulus: issue loads at arbitrary cycles.
  - Response: the an_o sequence and its 4-cycle dwell time are unchanged.
